// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dct_pkg
// Brief    : Shared defaults and FSM state encoding for the DCT MAC sequencer.
// Revision : 1.0
// ============================================================================
package dct_pkg;

    localparam int DEF_N_TAPS = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_OUT_W  = 12;
    localparam int DEF_SHIFT  = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage : dct_pkg
`default_nettype wire

// File: rtl/dct_mac_scale.sv
`default_nettype none
// ============================================================================
// Module   : dct_mac_scale
// Brief    : Combinational arithmetic shift (optionally round-half-up when
//            DCT_MAC_ROUND_EN is defined) and saturation of the accumulator.
// Revision : 1.0
// ============================================================================
module dct_mac_scale #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 12,
    parameter int SHIFT = 11
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] scaled
);

    // Clamp bounds expressed at ACC_W+1 bits so they compare directly with the shifted value.
    localparam logic signed [ACC_W:0] c_max = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_min = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] w_sh;

    assign w_ext = {acc[ACC_W-1], acc};

`ifdef DCT_MAC_ROUND_EN
    localparam logic signed [ACC_W:0] c_half = {{ACC_W{1'b0}}, 1'b1} << (SHIFT-1);
    logic signed [ACC_W:0] w_sum;
    assign w_sum = w_ext + c_half;
    assign w_sh  = w_sum >>> SHIFT;
`else
    assign w_sh  = w_ext >>> SHIFT;
`endif

    always_comb begin
        scaled = w_sh[OUT_W-1:0];
        if (w_sh > c_max) begin
            scaled = c_max[OUT_W-1:0];
        end else if (w_sh < c_min) begin
            scaled = c_min[OUT_W-1:0];
        end
    end

endmodule : dct_mac_scale
`default_nettype wire

// File: rtl/dct_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : dct_mac_seq
// Brief    : Sequences N_TAPS sample beats into an external MAC, waits out the
//            MAC latency, then presents the scaled result with valid/ready.
//            Optional rounding: define DCT_MAC_ROUND_EN.
// Revision : 1.0
// ============================================================================
module dct_mac_seq
    import dct_pkg::*;
#(
    parameter int N_TAPS  = DEF_N_TAPS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT   = DEF_SHIFT,
    parameter int MAC_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      mac_en,
    output logic                      mac_clr,
    output logic [DATA_W-1:0]         mac_a,
    output logic [$clog2(N_TAPS)-1:0] mac_coef_idx,
    input  logic [ACC_W-1:0]          mac_acc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      busy
);

    localparam int CNT_W = $clog2(N_TAPS);
    localparam logic [CNT_W-1:0] c_last_tap   = CNT_W'(N_TAPS - 1);
    localparam logic [2:0]       c_last_drain = 3'(MAC_LAT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_drain;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic              w_accept;
    logic [OUT_W-1:0]  w_scaled;

    // Forcing in_ready low under reset keeps the MAC untouched during reset.
    assign in_ready     = !rst && ((r_state == ST_IDLE) || (r_state == ST_ACCUM));
    assign w_accept     = in_valid && in_ready;
    assign mac_en       = w_accept;
    assign mac_clr      = w_accept && (r_cnt == '0);
    assign mac_a        = in_data;
    assign mac_coef_idx = r_cnt;
    assign out_valid    = r_out_valid && !rst;
    assign out_data     = r_out_data;
    assign busy         = !rst && (r_state != ST_IDLE);

    dct_mac_scale #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_scale (
        .acc    (mac_acc),
        .scaled (w_scaled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_drain     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_accept) begin
                        if (r_cnt == c_last_tap) begin
                            r_cnt   <= '0;
                            r_drain <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last product lands in mac_acc after MAC_LAT cycles; capture it then.
                    if (r_drain == c_last_drain) begin
                        r_out_data  <= w_scaled;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : dct_mac_seq
`default_nettype wire

// File: tb/tb_dct_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct_mac_seq
// Brief    : Directed self-checking bench for dct_mac_seq with a stub MAC.
// Revision : 1.0
// ============================================================================
module tb_dct_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mac_en;
    logic        mac_clr;
    logic [7:0]  mac_a;
    logic [2:0]  mac_coef_idx;
    logic [23:0] mac_acc;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    dct_mac_seq dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .mac_a        (mac_a),
        .mac_coef_idx (mac_coef_idx),
        .mac_acc      (mac_acc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full result: 8 beats (optional input gap), drain, held output, handshake.
    task automatic frame(input logic [23:0] acc, input int exp, input int gap_at,
                         input int gap_len, input int hold);
        mac_acc = acc;
        for (int k = 0; k < 8; k++) begin
            in_valid  = 1'b1;
            in_data   = 8'(k * 37 - 100);
            out_ready = 1'b0;
            #4;
            chk("beat_in_ready", in_ready, 1);
            chk("beat_mac_en", mac_en, 1);
            chk("beat_mac_clr", mac_clr, (k == 0) ? 1 : 0);
            chk("beat_coef_idx", mac_coef_idx, k);
            chk("beat_mac_a", mac_a, in_data);
            tick();
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    #4;
                    chk("gap_mac_en", mac_en, 0);
                    chk("gap_coef_idx", mac_coef_idx, k + 1);
                    chk("gap_busy", busy, 1);
                    tick();
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            in_valid = 1'b1;
            #4;
            chk("drain_in_ready", in_ready, 0);
            chk("drain_mac_en", mac_en, 0);
            chk("drain_mac_clr", mac_clr, 0);
            chk("drain_busy", busy, 1);
            chk("drain_out_valid", out_valid, 0);
            tick();
        end
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            #4;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", $signed(out_data), exp);
            chk("hold_mac_en", mac_en, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #4;
        chk("out_valid", out_valid, 1);
        chk("out_data", $signed(out_data), exp);
        tick();
        out_ready = 1'b0;
        #4;
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_round_a;
        int exp_round_b;
`ifdef DCT_MAC_ROUND_EN
        exp_round_a = 6;
        exp_round_b = 0;
`else
        exp_round_a = 5;
        exp_round_b = -1;
`endif
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        out_ready = 1'b0;
        mac_acc   = '0;
        tick();
        tick();
        #4;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_coef_idx", mac_coef_idx, 0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();

        // Back-to-back beats, nominal value
        frame(24'd73728, 36, -1, 0, 0);
        // Rounding-sensitive values
        frame(24'd11264, exp_round_a, -1, 0, 1);
        frame(-24'sd1024, exp_round_b, -1, 0, 0);
        // Saturation both ways
        frame(24'd6144000, 2047, -1, 0, 0);
        frame(-24'sd6144000, -2048, -1, 0, 0);
        // Input gap after beat 4 plus output backpressure
        frame(24'd73728, 36, 4, 3, 5);

        // Reset mid-frame after beat 4
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            #4;
            chk("pre_rst_coef_idx", mac_coef_idx, k);
            tick();
        end
        rst = 1'b1;
        #4;
        chk("mid_rst_mac_en", mac_en, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #4;
        chk("after_rst_in_ready", in_ready, 1);
        chk("after_rst_busy", busy, 0);
        chk("after_rst_out_valid", out_valid, 0);
        chk("after_rst_coef_idx", mac_coef_idx, 0);
        tick();
        frame(24'd6144000, 2047, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dct_mac_seq
`default_nettype wire

// File: doc/dct_mac_seq.md
DCT_MAC_SEQ -- requirements
Module: dct_mac_seq

Interface
REQ-001 Parameter N_TAPS, default 8: number of sample/coefficient products accumulated per result.
REQ-002 Parameter DATA_W, default 8: signed input sample width.
REQ-003 Parameter ACC_W, default 24: signed MAC accumulator width.
REQ-004 Parameter OUT_W, default 12: signed result width.
REQ-005 Parameter SHIFT, default 11: coefficient fraction bits removed from the accumulator.
REQ-006 Parameter MAC_LAT, default 2, range 1..7: cycles from mac_en to the matching mac_acc update.
REQ-007 clk  in  1  sole clock; all logic on the rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 in_valid  in  1  sample beat valid.
REQ-010 in_ready  out  1  sequencer accepts a beat.
REQ-011 in_data  in  DATA_W  signed sample.
REQ-012 mac_en  out  1  MAC multiply-accumulate enable.
REQ-013 mac_clr  out  1  MAC loads the product instead of accumulating.
REQ-014 mac_a  out  DATA_W  sample operand to the MAC.
REQ-015 mac_coef_idx  out  clog2(N_TAPS)  coefficient ROM index.
REQ-016 mac_acc  in  ACC_W  signed MAC accumulator value.
REQ-017 out_valid  out  1  result valid.
REQ-018 out_ready  in  1  consumer accepts the result.
REQ-019 out_data  out  OUT_W  signed scaled result.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 States: IDLE, ACCUM, DRAIN, OUT. A beat is accepted when in_valid && in_ready.
REQ-022 in_ready is high in IDLE and ACCUM and low in DRAIN and OUT.
REQ-023 mac_en = accept (combinational). mac_a = in_data (combinational). mac_coef_idx = beat counter.
REQ-024 mac_clr is high only on the accepted beat whose counter is 0.
REQ-025 Counter transitions: 0 to N_TAPS-1 on accepted beats, then wraps to 0. Gaps with in_valid low hold the counter and keep mac_en low.
REQ-026 IDLE to ACCUM on the first accept. ACCUM to DRAIN on the accept at counter N_TAPS-1.
REQ-027 DRAIN lasts exactly MAC_LAT cycles. On its last cycle out_data is registered from mac_acc, and the next state is OUT.
REQ-028 With the first accept at cycle t and no gaps, out_valid first goes high at cycle t+N_TAPS+MAC_LAT.
REQ-029 out_data = saturate_OUT_W(mac_acc >>> SHIFT), using an arithmetic shift. Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-030 In OUT, out_valid and out_data stay stable until out_ready. On out_valid && out_ready the block returns to IDLE, and out_valid goes low the next cycle.
REQ-031 in_valid during DRAIN and OUT is ignored: no accept and no MAC side-effect.

Reset
REQ-032 While rst is high: state=IDLE, counter=0, out_valid=0, out_data=0, busy=0. mac_en and mac_clr are 0 because in_ready is forced 0 during reset.
REQ-033 rst mid-operation discards the partial accumulation. The first accepted beat after reset asserts mac_clr with mac_coef_idx=0.

Configuration
REQ-034 Macro DCT_MAC_ROUND_EN defined: round half up, i.e. out_data = saturate((mac_acc + 2^(SHIFT-1)) >>> SHIFT), with the addition done at ACC_W+1 bits so it cannot overflow.
REQ-035 Macro DCT_MAC_ROUND_EN undefined: truncation per REQ-029, and no rounding adder is instantiated.

Structure
REQ-036 The state enum and the default widths (N_TAPS, DATA_W, ACC_W, OUT_W, SHIFT) live in the shared package dct_pkg.
REQ-037 The shift/round/saturate logic is the sub-module dct_mac_scale. It is purely combinational and is instantiated once. The FSM, counter and output register stay in dct_mac_seq.

Verification
REQ-038 Bench uses default parameters with a stub MAC that drives mac_acc directly. The scenarios below SHALL be covered:
- V1: 8 back-to-back beats from cycle t → mac_clr only at t; mac_coef_idx 0..7; in_ready low t+8..; out_valid at t+10.
- V2: mac_acc = 73728 at capture → out_data = 36 in both builds.
- V3: mac_acc = 11264 → out_data 6 with DCT_MAC_ROUND_EN, 5 without; mac_acc = -1024 → 0 with the macro, -1 without.
- V4: mac_acc = 6144000 → out_data 2047; mac_acc = -6144000 → out_data -2048.
- V5: in_valid low for 3 cycles after beat 4, and out_ready low for 5 cycles → counter holds during the gap; out_data stable; one result delivered; mac_en never high in DRAIN/OUT.
- V6: rst pulsed one cycle after beat 4 → next cycle in_ready=1, busy=0, out_valid=0; next accepted beat has mac_clr=1 and mac_coef_idx=0.
